split_cost_sequencer: RTL and testbench
=======================================

Name: split_cost_sequencer

Overview:
- Producer side of the minimum/k tracking path in the chain multiplier.
- For one (i,j) cell, walks split index k over [k_lo, k_hi) and reads the three cost terms for each k from the cost store.
- Forms a saturating 32-bit candidate cost and streams (cost, k) pairs over a valid/ready handshake into the minimum register / k register pair, marking the last candidate.

Parameters:
- DW, 32: cost data width. The saturation value is all-ones, which equals the minimum register's init value 32'hFFFFFFFF.
- KW, 8: split index width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that launches a sweep. Sampled only in IDLE.
- k_lo  in  KW  first split index. Latched on an accepted start.
- k_hi  in  KW  exclusive upper split index. Latched on an accepted start.
- busy  out  1  high from an accepted start until the done pulse, inclusive.
- rd_en  out  1  cost store read strobe.
- rd_k  out  KW  cost store read index.
- rd_left  in  DW  m[i][k]. Valid exactly 1 cycle after rd_en.
- rd_right  in  DW  m[k+1][j]. Valid exactly 1 cycle after rd_en.
- rd_prod  in  DW  p[i-1]*p[k]*p[j]. Valid exactly 1 cycle after rd_en.
- cand_valid  out  1  candidate present.
- cand_ready  in  1  downstream accepts.
- cand_cost  out  DW  saturated rd_left + rd_right + rd_prod.
- cand_k  out  KW  k of the candidate.
- cand_last  out  1  candidate has k == k_hi-1.
- done  out  1  one-cycle pulse at sweep end.
- empty  out  1  valid with done: set when the range had no candidates.

Behaviour:
- Reset (asynchronous, any state, including mid-sweep):
  - State goes to IDLE.
  - busy, rd_en, cand_valid, cand_last, done and empty go to 0.
  - rd_k, cand_k and cand_cost go to 0.
  - The internal k counter and latched bounds are cleared.
  - No partial candidate survives reset.
- FSM states:
  - IDLE:
    - On start: latch k_lo and k_hi, set k = k_lo, assert busy.
    - If k_lo >= k_hi, go to FIN with empty=1; otherwise go to RD.
    - start outside IDLE is ignored, with no queuing.
  - RD: rd_en=1 and rd_k=k for exactly one cycle; next state is CAP.
  - CAP:
    - Register cand_cost = sat(rd_left + rd_right + rd_prod), cand_k = k, cand_last = (k == k_hi-1).
    - Set cand_valid=1; next state is OUT.
  - OUT:
    - Hold cand_valid and all cand_* outputs stable until cand_ready is sampled high.
    - On cand_ready with cand_last=0: drop cand_valid, k <= k+1, go to RD.
    - On cand_ready with cand_last=1: drop cand_valid, go to FIN.
  - FIN: done=1 for one cycle, empty as computed, busy deasserts the following cycle; return to IDLE.
- Arithmetic:
  - The sum is computed at DW+2 bits.
  - Any result > 2^DW-1 yields all-ones, so overflow can never produce a spuriously small minimum.
- Timing and throughput:
  - Latency from start to first cand_valid is 3 cycles (IDLE→RD→CAP→OUT).
  - Steady state is one candidate per 3 cycles when cand_ready is held high.
- Handshake rules:
  - cand_valid never drops without a handshake.
  - cand_ready while cand_valid=0 is ignored.
  - cand_k increases strictly by 1 between successive candidates.
- Boundaries:
  - k_hi = 2^KW is unrepresentable: ranges are limited to k_hi <= 2^KW-1.
  - The k counter never wraps because last is detected before increment.
  - k_hi == k_lo+1 gives a single candidate with cand_last=1.
  - start asserted in the same cycle as done is ignored; start the cycle after is accepted.

Test Plan:
- Single split: reset, start with k_lo=3, k_hi=4, rd_left=10, rd_right=20, rd_prod=5, cand_ready=1 → exactly one candidate {cost=35, k=3, last=1}; done pulses, empty=0, busy low after.
- Sweep with backpressure:
  - Stimulus: k_lo=0, k_hi=4; cost store returns costs 50, 12, 40, 12 for k=0..3; cand_ready toggles 1-of-3 cycles.
  - Required: candidates k=0,1,2,3 in order, outputs stable while stalled, last only on k=3.
  - Downstream minimum register ends at 12 with k=1 (first minimum kept).
- Saturation: rd_left=32'hFFFFFFF0, rd_right=32'h20, rd_prod=0 → cand_cost=32'hFFFFFFFF.
- Empty range: k_lo=5, k_hi=5 → no rd_en and no cand_valid; done=1 with empty=1, 1 cycle after start.
- Reset mid-sweep: assert rst while in OUT with cand_valid=1 → cand_valid, busy and done are 0 immediately (asynchronous). A new start with k_lo=2, k_hi=3 after release yields k=2 only.
- Start while busy: pulse start during a k_lo=0, k_hi=3 sweep with k_lo=7 → ignored; sweep emits k=0,1,2 unchanged.

Source files
------------

// File: rtl/split_cost_if.sv
// Handshake and cost-store bundle between the split-cost sequencer and its environment.
// The slave modport is the sequencer's view; the master modport is the driving side.
interface split_cost_if #(
    parameter int DW = 32,
    parameter int KW = 8
);
    logic          start;
    logic [KW-1:0] k_lo;
    logic [KW-1:0] k_hi;
    logic          busy;
    logic          rd_en;
    logic [KW-1:0] rd_k;
    logic [DW-1:0] rd_left;
    logic [DW-1:0] rd_right;
    logic [DW-1:0] rd_prod;
    logic          cand_valid;
    logic          cand_ready;
    logic [DW-1:0] cand_cost;
    logic [KW-1:0] cand_k;
    logic          cand_last;
    logic          done;
    logic          empty;

    modport master (
        output start, k_lo, k_hi, rd_left, rd_right, rd_prod, cand_ready,
        input  busy, rd_en, rd_k, cand_valid, cand_cost, cand_k, cand_last, done, empty
    );

    modport slave (
        input  start, k_lo, k_hi, rd_left, rd_right, rd_prod, cand_ready,
        output busy, rd_en, rd_k, cand_valid, cand_cost, cand_k, cand_last, done, empty
    );
endinterface

// File: rtl/split_cost_sequencer.sv
// Walks split index k over [k_lo, k_hi) for one chain-multiplier cell and streams
// saturated (cost, k) candidates to the minimum/k register pair over valid/ready.
module split_cost_sequencer #(
    parameter int DW = 32,
    parameter int KW = 8
) (
    input  logic         clk,
    input  logic         rst,
    split_cost_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_OUT  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    localparam logic [KW-1:0] K_ONE = {{(KW-1){1'b0}}, 1'b1};

    // Three-term add at DW+2 bits; any carry out clamps to all-ones so an overflow
    // can never look like a small minimum.
    function automatic logic [DW-1:0] sat_add3(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b,
        input logic [DW-1:0] c
    );
        logic [DW+1:0] sum;
        sum = {2'b00, a} + {2'b00, b} + {2'b00, c};
        if (sum[DW+1:DW] != 2'b00) begin
            sat_add3 = {DW{1'b1}};
        end else begin
            sat_add3 = sum[DW-1:0];
        end
    endfunction

    state_t        r_state;
    logic [KW-1:0] r_k;
    logic [KW-1:0] r_k_hi;
    logic          r_busy;
    logic          r_rd_en;
    logic [KW-1:0] r_rd_k;
    logic          r_cand_valid;
    logic [DW-1:0] r_cand_cost;
    logic [KW-1:0] r_cand_k;
    logic          r_cand_last;
    logic          r_done;
    logic          r_empty;

    state_t        w_state_nxt;
    logic [KW-1:0] w_k_nxt;
    logic [KW-1:0] w_k_hi_nxt;
    logic          w_busy_nxt;
    logic          w_rd_en_nxt;
    logic [KW-1:0] w_rd_k_nxt;
    logic          w_cand_valid_nxt;
    logic [DW-1:0] w_cand_cost_nxt;
    logic [KW-1:0] w_cand_k_nxt;
    logic          w_cand_last_nxt;
    logic          w_done_nxt;
    logic          w_empty_nxt;

    // Next-state and next-output decode; all outputs are registered from these values.
    always_comb begin
        w_state_nxt      = r_state;
        w_k_nxt          = r_k;
        w_k_hi_nxt       = r_k_hi;
        w_busy_nxt       = r_busy;
        w_rd_en_nxt      = 1'b0;
        w_rd_k_nxt       = r_rd_k;
        w_cand_valid_nxt = r_cand_valid;
        w_cand_cost_nxt  = r_cand_cost;
        w_cand_k_nxt     = r_cand_k;
        w_cand_last_nxt  = r_cand_last;
        w_done_nxt       = 1'b0;
        w_empty_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_k_nxt    = bus.k_lo;
                    w_k_hi_nxt = bus.k_hi;
                    w_busy_nxt = 1'b1;
                    if (bus.k_lo >= bus.k_hi) begin
                        w_state_nxt = ST_FIN;
                        w_done_nxt  = 1'b1;
                        w_empty_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_RD;
                        w_rd_en_nxt = 1'b1;
                        w_rd_k_nxt  = bus.k_lo;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD: begin
                // Read data for r_k arrives during CAP.
                w_state_nxt = ST_CAP;
            end
            ST_CAP: begin
                w_cand_cost_nxt  = sat_add3(bus.rd_left, bus.rd_right, bus.rd_prod);
                w_cand_k_nxt     = r_k;
                w_cand_last_nxt  = (r_k == (r_k_hi - K_ONE));
                w_cand_valid_nxt = 1'b1;
                w_state_nxt      = ST_OUT;
            end
            ST_OUT: begin
                if (bus.cand_ready) begin
                    w_cand_valid_nxt = 1'b0;
                    if (r_cand_last) begin
                        // Last is known before any increment, so k never wraps.
                        w_state_nxt = ST_FIN;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_k_nxt     = r_k + K_ONE;
                        w_state_nxt = ST_RD;
                        w_rd_en_nxt = 1'b1;
                        w_rd_k_nxt  = r_k + K_ONE;
                    end
                end else begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_FIN: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt      = ST_IDLE;
                w_busy_nxt       = 1'b0;
                w_cand_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, sweep bookkeeping and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_k          <= {KW{1'b0}};
            r_k_hi       <= {KW{1'b0}};
            r_busy       <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rd_k       <= {KW{1'b0}};
            r_cand_valid <= 1'b0;
            r_cand_cost  <= {DW{1'b0}};
            r_cand_k     <= {KW{1'b0}};
            r_cand_last  <= 1'b0;
            r_done       <= 1'b0;
            r_empty      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_k          <= w_k_nxt;
            r_k_hi       <= w_k_hi_nxt;
            r_busy       <= w_busy_nxt;
            r_rd_en      <= w_rd_en_nxt;
            r_rd_k       <= w_rd_k_nxt;
            r_cand_valid <= w_cand_valid_nxt;
            r_cand_cost  <= w_cand_cost_nxt;
            r_cand_k     <= w_cand_k_nxt;
            r_cand_last  <= w_cand_last_nxt;
            r_done       <= w_done_nxt;
            r_empty      <= w_empty_nxt;
        end
    end

    assign bus.busy       = r_busy;
    assign bus.rd_en      = r_rd_en;
    assign bus.rd_k       = r_rd_k;
    assign bus.cand_valid = r_cand_valid;
    assign bus.cand_cost  = r_cand_cost;
    assign bus.cand_k     = r_cand_k;
    assign bus.cand_last  = r_cand_last;
    assign bus.done       = r_done;
    assign bus.empty      = r_empty;

endmodule

// File: tb/tb_split_cost_sequencer.sv
// Bench for split_cost_sequencer: cost-store responder, sweep scoreboard built from
// plain arithmetic over the cost arrays, and a downstream minimum register model.
module tb_split_cost_sequencer;
    localparam int DW = 32;
    localparam int KW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    split_cost_if #(.DW(DW), .KW(KW)) bus ();

    split_cost_sequencer #(.DW(DW), .KW(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem_l [256];
    logic [31:0] mem_r [256];
    logic [31:0] mem_p [256];
    logic [31:0] min_cost;
    int          min_k;
    logic [31:0] last_cost;
    int          n_cands;
    logic        rd_seen = 1'b0;
    logic [7:0]  rd_idx  = 8'd0;

    // Cost store: data for a read is valid only in the cycle after rd_en, garbage otherwise.
    always @(negedge clk) begin
        rd_seen = bus.rd_en;
        rd_idx  = bus.rd_k;
    end
    always @(posedge clk) begin
        #1;
        if (rd_seen) begin
            bus.rd_left  = mem_l[rd_idx];
            bus.rd_right = mem_r[rd_idx];
            bus.rd_prod  = mem_p[rd_idx];
        end else begin
            bus.rd_left  = $urandom;
            bus.rd_right = $urandom;
            bus.rd_prod  = $urandom;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_cost(input int k);
        logic [63:0] s;
        s = {32'h0, mem_l[k]} + {32'h0, mem_r[k]} + {32'h0, mem_p[k]};
        if (s > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
        return s[31:0];
    endfunction

    // rmode: 0 always ready, 1 ready one cycle in three, 2 random ready.
    task automatic run_sweep(input int lo, input int hi, input int rmode,
                             input int inj_cyc, input bit inj_done);
        logic [31:0] q_cost[$];
        int          q_k[$];
        logic [31:0] h_cost;
        logic [7:0]  h_k;
        logic        h_last;
        int          exp_rd, cyc, first_v, done_cyc, n_rd;
        bit          prev_v, prev_r, r, got_done;
        for (int k = lo; k < hi; k++) begin
            q_cost.push_back(ref_cost(k));
            q_k.push_back(k);
        end
        exp_rd = lo; first_v = -1; done_cyc = -1; n_rd = 0;
        prev_v = 1'b0; prev_r = 1'b0; got_done = 1'b0;
        h_cost = 32'h0; h_k = 8'h0; h_last = 1'b0;
        min_cost = 32'hFFFF_FFFF; min_k = -1; n_cands = 0;
        bus.k_lo = 8'(lo); bus.k_hi = 8'(hi); bus.start = 1'b1; bus.cand_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!got_done && cyc < 2000) begin
            chk("busy_hi", 64'(bus.busy), 64'd1);
            if (bus.rd_en) begin
                chk("rd_k", 64'(bus.rd_k), 64'(exp_rd));
                n_rd++;
            end
            if (bus.cand_valid) begin
                if (first_v < 0) first_v = cyc;
                if (prev_v && !prev_r) begin
                    chk("stall_cost", 64'(bus.cand_cost), 64'(h_cost));
                    chk("stall_k",    64'(bus.cand_k),    64'(h_k));
                    chk("stall_last", 64'(bus.cand_last), 64'(h_last));
                end else if (q_k.size() == 0) begin
                    chk("cand_extra", 64'd1, 64'd0);
                end else begin
                    chk("cand_cost", 64'(bus.cand_cost), 64'(q_cost[0]));
                    chk("cand_k",    64'(bus.cand_k),    64'(q_k[0]));
                    chk("cand_last", 64'(bus.cand_last), 64'(q_k[0] == hi - 1));
                    h_cost = bus.cand_cost; h_k = bus.cand_k; h_last = bus.cand_last;
                end
            end
            if (bus.done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                chk("empty",      64'(bus.empty), 64'(lo >= hi));
                chk("cands_left", 64'(q_k.size()), 64'd0);
            end
            if (rmode == 0)      r = 1'b1;
            else if (rmode == 1) r = (cyc % 3 == 1);
            else                 r = 1'($urandom_range(0, 1));
            bus.cand_ready = r;
            bus.start = (cyc == inj_cyc) || (got_done && inj_done);
            if (bus.start) begin
                bus.k_lo = 8'd7;
                bus.k_hi = 8'd9;
            end
            if (bus.cand_valid && r) begin
                if (bus.cand_cost < min_cost) begin
                    min_cost = bus.cand_cost;
                    min_k    = int'(bus.cand_k);
                end
                last_cost = bus.cand_cost;
                n_cands++;
                if (q_k.size() > 0) begin
                    void'(q_k.pop_front());
                    void'(q_cost.pop_front());
                end
                exp_rd++;
            end
            prev_v = bus.cand_valid;
            prev_r = r;
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        bus.cand_ready = 1'b0;
        if (!got_done) chk("done_timeout", 64'd0, 64'd1);
        chk("busy_after",  64'(bus.busy),       64'd0);
        chk("done_after",  64'(bus.done),       64'd0);
        chk("valid_after", 64'(bus.cand_valid), 64'd0);
        chk("rd_after",    64'(bus.rd_en),      64'd0);
        chk("rd_count",    64'(n_rd),           64'((hi > lo) ? (hi - lo) : 0));
        if (hi > lo) chk("first_latency", 64'(first_v), 64'd3);
        else         chk("empty_latency", 64'(done_cyc), 64'd1);
    endtask

    initial begin
        logic [31:0] bp[4];
        int          lo, hi, cyc;
        bp = '{32'd50, 32'd12, 32'd40, 32'd12};
        bus.start = 1'b0; bus.k_lo = 8'd0; bus.k_hi = 8'd0; bus.cand_ready = 1'b0;
        bus.rd_left = 32'h0; bus.rd_right = 32'h0; bus.rd_prod = 32'h0;
        for (int k = 0; k < 256; k++) begin
            mem_l[k] = 32'h0; mem_r[k] = 32'h0; mem_p[k] = 32'h0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy",  64'(bus.busy),       64'd0);
        chk("rst_rd_en", 64'(bus.rd_en),      64'd0);
        chk("rst_rd_k",  64'(bus.rd_k),       64'd0);
        chk("rst_valid", 64'(bus.cand_valid), 64'd0);
        chk("rst_cost",  64'(bus.cand_cost),  64'd0);
        chk("rst_k",     64'(bus.cand_k),     64'd0);
        chk("rst_last",  64'(bus.cand_last),  64'd0);
        chk("rst_done",  64'(bus.done),       64'd0);
        chk("rst_empty", 64'(bus.empty),      64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single split.
        mem_l[3] = 32'd10; mem_r[3] = 32'd20; mem_p[3] = 32'd5;
        run_sweep(3, 4, 0, -1, 1'b0);
        chk("single_cost",  64'(last_cost), 64'd35);
        chk("single_count", 64'(n_cands),   64'd1);

        // Backpressured sweep; a start on the done cycle must be dropped.
        for (int k = 0; k < 4; k++) begin
            mem_l[k] = bp[k]; mem_r[k] = 32'h0; mem_p[k] = 32'h0;
        end
        run_sweep(0, 4, 1, -1, 1'b1);
        chk("bp_min_cost", 64'(min_cost), 64'd12);
        chk("bp_min_k",    64'(min_k),    64'd1);
        chk("bp_count",    64'(n_cands),  64'd4);

        // Saturation, launched the cycle right after the previous sweep went idle.
        mem_l[9]  = 32'hFFFF_FFF0; mem_r[9]  = 32'h20;        mem_p[9]  = 32'h0;
        mem_l[10] = 32'hFFFF_FFF0; mem_r[10] = 32'hF;         mem_p[10] = 32'h0;
        mem_l[11] = 32'hFFFF_FFFF; mem_r[11] = 32'hFFFF_FFFF; mem_p[11] = 32'hFFFF_FFFF;
        run_sweep(9, 10, 0, -1, 1'b0);
        chk("sat_cost", 64'(last_cost), 64'hFFFF_FFFF);
        run_sweep(10, 12, 2, -1, 1'b0);

        // Empty and inverted ranges.
        run_sweep(5, 5, 0, -1, 1'b0);
        run_sweep(6, 2, 0, -1, 1'b0);

        // Start while busy is ignored.
        for (int k = 0; k < 3; k++) begin
            mem_l[k] = $urandom_range(0, 1000); mem_r[k] = $urandom_range(0, 1000); mem_p[k] = 32'd7;
        end
        run_sweep(0, 3, 0, 4, 1'b0);
        chk("busy_start_count", 64'(n_cands), 64'd3);

        // Top of the representable range.
        for (int k = 252; k < 255; k++) begin
            mem_l[k] = $urandom; mem_r[k] = $urandom_range(0, 99); mem_p[k] = $urandom_range(0, 99);
        end
        run_sweep(252, 255, 2, -1, 1'b0);

        // Asynchronous reset while a candidate is waiting.
        bus.k_lo = 8'd0; bus.k_hi = 8'd4; bus.start = 1'b1; bus.cand_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.cand_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_valid_seen", 64'(bus.cand_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(bus.cand_valid), 64'd0);
        chk("mid_rst_busy",  64'(bus.busy),       64'd0);
        chk("mid_rst_done",  64'(bus.done),       64'd0);
        chk("mid_rst_cost",  64'(bus.cand_cost),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_l[2] = 32'd100; mem_r[2] = 32'd1; mem_p[2] = 32'd2;
        run_sweep(2, 3, 0, -1, 1'b0);
        chk("post_rst_cost",  64'(last_cost), 64'd103);
        chk("post_rst_count", 64'(n_cands),   64'd1);

        // Randomized ranges, costs and backpressure.
        repeat (10) begin
            lo = $urandom_range(0, 30);
            hi = $urandom_range(0, 34);
            for (int k = lo; k < hi; k++) begin
                mem_l[k] = $urandom;
                mem_r[k] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 500));
                mem_p[k] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 500));
            end
            run_sweep(lo, hi, 2, -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
